// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets three byte-stream requesters share one UART
// transmitter. A granted requester keeps ownership until its whole message has been sent.
module uart_tx_arbiter #(
   parameter int BUSY_TIMEOUT = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] req,
   input  logic [7:0] din0,
   input  logic [7:0] din1,
   input  logic [7:0] din2,
   input  logic [2:0] last,
   input  logic       tx_busy,
   output logic       tx_start,
   output logic [7:0] tx_data,
   output logic [2:0] ack,
   output logic [2:0] grant,
   output logic       busy,
   output logic       err
);

   localparam int TW = $clog2(BUSY_TIMEOUT + 1);
   localparam logic [TW-1:0] TMAX = TW'(BUSY_TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, LOAD, WAIT_BUSY, WAIT_DONE} state_t;

   state_t        state;
   logic [1:0]    owner;
   logic [1:0]    last_grant;
   logic [1:0]    pick;
   logic [TW-1:0] timer;
   logic          last_flag;
   logic [7:0]    owner_din;
   logic          owner_req;
   logic          owner_last;

   // Search order starts just after the previous owner. Only consulted when req is non-zero,
   // so the final fall-through candidate is then guaranteed to be requesting.
   always_comb begin
      case (last_grant)
         2'd0:    pick = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
         2'd1:    pick = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
         default: pick = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
      endcase
   end

   always_comb begin
      owner_din = 8'h00;
      case (owner)
         2'd0:    owner_din = din0;
         2'd1:    owner_din = din1;
         2'd2:    owner_din = din2;
         default: owner_din = 8'h00;
      endcase
   end

   assign owner_req  = |(req & grant);
   assign owner_last = |(last & grant);
   assign busy       = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         owner      <= 2'd0;
         last_grant <= 2'd2;
         timer      <= '0;
         last_flag  <= 1'b0;
         tx_start   <= 1'b0;
         tx_data    <= 8'h00;
         ack        <= 3'b000;
         grant      <= 3'b000;
         err        <= 1'b0;
      end else begin
         tx_start <= 1'b0;
         ack      <= 3'b000;
         case (state)
            IDLE: begin
               if (req != 3'b000) begin
                  owner <= pick;
                  grant <= 3'b001 << pick;
                  state <= LOAD;
               end
            end
            LOAD: begin
               if (!tx_busy) begin
                  tx_data   <= owner_din;
                  tx_start  <= 1'b1;
                  ack       <= grant;
                  last_flag <= owner_last;
                  timer     <= '0;
                  state     <= WAIT_BUSY;
               end
            end
            // A transmitter that never acknowledges the start pulse must not hang the bus.
            WAIT_BUSY: begin
               if (tx_busy) begin
                  state <= WAIT_DONE;
               end else if (timer == TMAX) begin
                  err        <= 1'b1;
                  grant      <= 3'b000;
                  last_grant <= owner;
                  state      <= IDLE;
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            WAIT_DONE: begin
               if (!tx_busy) begin
                  if (last_flag || !owner_req) begin
                     grant      <= 3'b000;
                     last_grant <= owner;
                     state      <= IDLE;
                  end else begin
                     state <= LOAD;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: a simple UART busy model plus a message-level
// round-robin reference that predicts the transmitted byte stream.
module tb_uart_tx_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] req;
   logic [7:0] din0, din1, din2;
   logic [2:0] last;
   logic       tx_busy;
   logic       tx_start;
   logic [7:0] tx_data;
   logic [2:0] ack;
   logic [2:0] grant;
   logic       busy;
   logic       err;

   int n_pass  = 0;
   int n_total = 0;

   logic       force_busy = 1'b0;
   logic       uart_dead  = 1'b0;
   logic       model_busy = 1'b0;
   int         frame_len  = 2;
   int         busy_cnt   = 0;

   logic [8:0] rq [3][$];
   logic [9:0] exp_q [$];

   uart_tx_arbiter #(.BUSY_TIMEOUT(8)) dut (
      .clk(clk), .rst(rst), .req(req), .din0(din0), .din1(din1), .din2(din2),
      .last(last), .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
      .ack(ack), .grant(grant), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   // UART stand-in: busy rises one cycle after a start pulse and lasts frame_len cycles.
   always @(negedge clk or posedge rst) begin
      if (rst) busy_cnt = 0;
      else if (tx_start && !uart_dead) busy_cnt = frame_len;
      else if (busy_cnt > 0) busy_cnt = busy_cnt - 1;
      model_busy = (busy_cnt > 0);
   end

   assign tx_busy = force_busy | model_busy;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got time limit reached, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      req = 3'b000; last = 3'b000;
      din0 = 8'h00; din1 = 8'h00; din2 = 8'h00;
      force_busy = 1'b0; uart_dead = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int cnt;
      cnt = 0;
      while (busy !== 1'b0 && cnt < budget) begin
         @(negedge clk);
         cnt++;
      end
   endtask

   task automatic drive_reqs();
      req[0]  = (rq[0].size() != 0);
      req[1]  = (rq[1].size() != 0);
      req[2]  = (rq[2].size() != 0);
      din0    = (rq[0].size() != 0) ? rq[0][0][7:0] : 8'h00;
      din1    = (rq[1].size() != 0) ? rq[1][0][7:0] : 8'h00;
      din2    = (rq[2].size() != 0) ? rq[2][0][7:0] : 8'h00;
      last[0] = (rq[0].size() != 0) ? rq[0][0][8] : 1'b0;
      last[1] = (rq[1].size() != 0) ? rq[1][0][8] : 1'b0;
      last[2] = (rq[2].size() != 0) ? rq[2][0][8] : 1'b0;
   endtask

   // Reference: whole messages are served in round-robin order starting after requester 2.
   task automatic build_expected();
      logic [8:0] m [3][$];
      logic [8:0] it;
      int ptr, c;
      bit found;
      for (int i = 0; i < 3; i++) m[i] = rq[i];
      exp_q.delete();
      ptr = 2;
      while (m[0].size() + m[1].size() + m[2].size() > 0) begin
         found = 1'b0;
         for (int k = 1; k <= 3; k++) begin
            c = (ptr + k) % 3;
            if (!found && m[c].size() > 0) begin
               found = 1'b1;
               do begin
                  it = m[c].pop_front();
                  exp_q.push_back({c[1:0], it[7:0]});
               end while (!it[8] && m[c].size() > 0);
               ptr = c;
            end
         end
      end
   endtask

   task automatic run_traffic(input string name, input int budget);
      int cyc, idx;
      logic prev_start, pulse_bad;
      cyc = 0; prev_start = 1'b0; pulse_bad = 1'b0;
      build_expected();
      drive_reqs();
      while ((exp_q.size() > 0 || busy !== 1'b0) && cyc < budget) begin
         logic [9:0] e;
         @(negedge clk);
         cyc++;
         if (tx_start === 1'b1) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 10'h3ff;
            n_total++;
            if ({ack, tx_data} !== {3'b001 << e[9:8], e[7:0]})
               $display("[TB] FAIL %s_byte: got ack=%b data=%h, required ack=%b data=%h",
                        name, ack, tx_data, 3'b001 << e[9:8], e[7:0]);
            else n_pass++;
            n_total++;
            if (grant !== ack)
               $display("[TB] FAIL %s_grant: got grant=%b, required %b", name, grant, ack);
            else n_pass++;
         end
         if (tx_start === 1'b1 && prev_start === 1'b1) pulse_bad = 1'b1;
         if (ack !== 3'b000 && tx_start !== 1'b1) pulse_bad = 1'b1;
         if ($countones(grant) > 1) pulse_bad = 1'b1;
         prev_start = tx_start;
         if (ack !== 3'b000) begin
            idx = ack[0] ? 0 : (ack[1] ? 1 : 2);
            if (rq[idx].size() > 0) void'(rq[idx].pop_front());
         end
         drive_reqs();
      end
      n_total++;
      if ({exp_q.size() != 0, busy !== 1'b0} !== 2'b00)
         $display("[TB] FAIL %s_done: got %0d bytes pending busy=%b, required 0 pending busy=0",
                  name, exp_q.size(), busy);
      else n_pass++;
      n_total++;
      if (pulse_bad !== 1'b0)
         $display("[TB] FAIL %s_pulses: got illegal pulse/grant pattern=1, required 0", name);
      else n_pass++;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      #1;
      n_total++;
      if ({tx_start, tx_data, ack, grant, busy, err} !== 16'h0000)
         $display("[TB] FAIL reset_outputs: got %h, required 0000",
                  {tx_start, tx_data, ack, grant, busy, err});
      else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      frame_len = 2;
      req = 3'b111; last = 3'b111; din0 = 8'ha0; din1 = 8'ha1; din2 = 8'ha2;
      @(negedge clk);
      n_total++;
      if (grant !== 3'b001)
         $display("[TB] FAIL reset_priority: got grant=%b, required 001", grant);
      else n_pass++;
      @(negedge clk);
      n_total++;
      if ({tx_start, ack, tx_data} !== {1'b1, 3'b001, 8'ha0})
         $display("[TB] FAIL reset_first_byte: got start=%b ack=%b data=%h, required 1 001 a0",
                  tx_start, ack, tx_data);
      else n_pass++;
      req = 3'b000;
      wait_idle(50);
   endtask

   task automatic test_single();
      do_reset();
      frame_len = 3;
      req = 3'b001; din0 = 8'h31; last = 3'b001;
      @(negedge clk);
      n_total++;
      if ({grant, tx_start} !== {3'b001, 1'b0})
         $display("[TB] FAIL single_grant: got grant=%b start=%b, required 001 0", grant, tx_start);
      else n_pass++;
      @(negedge clk);
      n_total++;
      if ({tx_start, ack, tx_data} !== {1'b1, 3'b001, 8'h31})
         $display("[TB] FAIL single_start: got start=%b ack=%b data=%h, required 1 001 31",
                  tx_start, ack, tx_data);
      else n_pass++;
      req = 3'b000; last = 3'b000;
      wait_idle(50);
      n_total++;
      if ({busy, grant, tx_data} !== {1'b0, 3'b000, 8'h31})
         $display("[TB] FAIL single_end: got busy=%b grant=%b data=%h, required 0 000 31",
                  busy, grant, tx_data);
      else n_pass++;
   endtask

   task automatic test_busy_held();
      logic early, extra;
      do_reset();
      frame_len = 2;
      force_busy = 1'b1;
      req = 3'b010; din1 = 8'h5a; last = 3'b010;
      @(negedge clk);
      n_total++;
      if (grant !== 3'b010)
         $display("[TB] FAIL held_grant: got grant=%b, required 010", grant);
      else n_pass++;
      early = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (tx_start !== 1'b0 || ack !== 3'b000) early = 1'b1;
      end
      n_total++;
      if (early !== 1'b0)
         $display("[TB] FAIL held_no_pulse: got pulse while busy=1, required none");
      else n_pass++;
      force_busy = 1'b0;
      @(negedge clk);
      n_total++;
      if ({tx_start, ack, tx_data} !== {1'b1, 3'b010, 8'h5a})
         $display("[TB] FAIL held_release: got start=%b ack=%b data=%h, required 1 010 5a",
                  tx_start, ack, tx_data);
      else n_pass++;
      req = 3'b000;
      extra = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (tx_start !== 1'b0 || ack !== 3'b000) extra = 1'b1;
      end
      n_total++;
      if ({extra, busy} !== 2'b00)
         $display("[TB] FAIL held_single_pulse: got extra=%b busy=%b, required 0 0", extra, busy);
      else n_pass++;
   endtask

   task automatic test_timeout();
      logic early;
      int cnt;
      do_reset();
      uart_dead = 1'b1;
      req = 3'b001; din0 = 8'h77; last = 3'b001;
      @(negedge clk);
      @(negedge clk);
      n_total++;
      if (tx_start !== 1'b1)
         $display("[TB] FAIL timeout_start: got start=%b, required 1", tx_start);
      else n_pass++;
      req = 3'b000; last = 3'b000;
      early = 1'b0;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         if (err !== 1'b0 || busy !== 1'b1) early = 1'b1;
      end
      n_total++;
      if (early !== 1'b0)
         $display("[TB] FAIL timeout_early: got early err/idle=1, required 0");
      else n_pass++;
      @(negedge clk);
      n_total++;
      if ({err, grant, busy} !== {1'b1, 3'b000, 1'b0})
         $display("[TB] FAIL timeout_fire: got err=%b grant=%b busy=%b, required 1 000 0",
                  err, grant, busy);
      else n_pass++;
      uart_dead = 1'b0;
      frame_len = 2;
      req = 3'b100; din2 = 8'h11; last = 3'b100;
      cnt = 0;
      while (tx_start !== 1'b1 && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
      req = 3'b000; last = 3'b000;
      wait_idle(50);
      n_total++;
      if ({err, tx_data, busy} !== {1'b1, 8'h11, 1'b0})
         $display("[TB] FAIL timeout_sticky: got err=%b data=%h busy=%b, required 1 11 0",
                  err, tx_data, busy);
      else n_pass++;
      do_reset();
      n_total++;
      if (err !== 1'b0)
         $display("[TB] FAIL timeout_clear: got err=%b, required 0", err);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      int cnt;
      do_reset();
      frame_len = 6;
      req = 3'b010; din1 = 8'h21; last = 3'b000;
      cnt = 0;
      while (tx_start !== 1'b1 && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
      din1 = 8'h22;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      n_total++;
      if ({tx_start, tx_data, ack, grant, busy, err} !== 16'h0000)
         $display("[TB] FAIL midreset_zero: got %h, required 0000",
                  {tx_start, tx_data, ack, grant, busy, err});
      else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_total++;
      if ({grant, tx_start} !== {3'b010, 1'b0})
         $display("[TB] FAIL midreset_regrant: got grant=%b start=%b, required 010 0",
                  grant, tx_start);
      else n_pass++;
      @(negedge clk);
      n_total++;
      if ({tx_start, ack, tx_data} !== {1'b1, 3'b010, 8'h22})
         $display("[TB] FAIL midreset_start: got start=%b ack=%b data=%h, required 1 010 22",
                  tx_start, ack, tx_data);
      else n_pass++;
      req = 3'b000;
      wait_idle(50);
   endtask

   task automatic test_round_robin();
      do_reset();
      frame_len = 2;
      for (int i = 0; i < 3; i++) rq[i].delete();
      for (int r = 0; r < 2; r++)
         for (int i = 0; i < 3; i++)
            rq[i].push_back({1'b1, 4'(i + 1), 4'(r)});
      run_traffic("rr", 500);
   endtask

   task automatic test_message_hold();
      do_reset();
      frame_len = 2;
      for (int i = 0; i < 3; i++) rq[i].delete();
      rq[1].push_back({1'b0, 8'h31});
      rq[1].push_back({1'b0, 8'h32});
      rq[1].push_back({1'b1, 8'h33});
      rq[2].push_back({1'b1, 8'h40});
      run_traffic("hold", 500);
   endtask

   task automatic test_random();
      int nmsg, len;
      for (int round = 0; round < 4; round++) begin
         do_reset();
         frame_len = $urandom_range(1, 4);
         for (int i = 0; i < 3; i++) begin
            rq[i].delete();
            nmsg = $urandom_range(1, 3);
            for (int m = 0; m < nmsg; m++) begin
               len = $urandom_range(1, 3);
               for (int b = 0; b < len; b++)
                  rq[i].push_back({b == len - 1, 8'($urandom)});
            end
         end
         run_traffic("random", 2000);
      end
   endtask

   initial begin
      rst = 1'b1;
      req = 3'b000; last = 3'b000;
      din0 = 8'h00; din1 = 8'h00; din2 = 8'h00;
      test_reset();
      test_single();
      test_busy_held();
      test_timeout();
      test_reset_mid();
      test_round_robin();
      test_message_hold();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
